// File: rtl/exe_alu_stage.sv
// RV32 execute stage: operand select, ALU, branch compare, store masking, one register stage.
// Also holds the first-match key/data mux used for operand and branch selection.

module exe_key_mux #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 32
) (
  input  logic [KEY_LEN-1:0]                  key,
  input  logic [DATA_LEN-1:0]                 default_val,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                 data
);
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  logic found_s;

  // Lowest-index matching entry wins; default when nothing matches.
  always_comb begin
    data    = default_val;
    found_s = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (!found_s && (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key)) begin
        data    = lut[i*PAIR_LEN +: DATA_LEN];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
endmodule

module exe_alu_stage #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DATA_LEN-1:0] reg1_i,
  input  logic [DATA_LEN-1:0] reg2_i,
  input  logic [DATA_LEN-1:0] pc_i,
  input  logic [DATA_LEN-1:0] imm_i,
  input  logic [3:0]          alu_control,
  input  logic [3:0]          alu_sel,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [1:0]          store_type_i,
  input  logic [2:0]          load_type_i,
  input  logic [2:0]          branch_type_i,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] alu_result_o,
  output logic                branch_request_o,
  output logic                mem_wen_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [2:0]          load_type_o
);
  logic [DATA_LEN-1:0] src1_s, src2_s, alu_res_s, store_mask_s;
  logic [4:0]          shamt_s;
  logic                zero_s, lt_s, ltu_s, branch_s;

  exe_key_mux #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(DATA_LEN)) u_src1_mux (
    .key         (alu_sel[1:0]),
    .default_val ({DATA_LEN{1'b0}}),
    .lut         ({2'b10, pc_i, 2'b01, reg1_i, 2'b00, {DATA_LEN{1'b0}}}),
    .data        (src1_s)
  );

  exe_key_mux #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(DATA_LEN)) u_src2_mux (
    .key         (alu_sel[3:2]),
    .default_val ({DATA_LEN{1'b0}}),
    .lut         ({2'b11, 32'd4, 2'b10, imm_i, 2'b01, reg2_i, 2'b00, {DATA_LEN{1'b0}}}),
    .data        (src2_s)
  );

  assign shamt_s = src2_s[4:0];
  assign zero_s  = (src1_s == src2_s);
  assign lt_s    = ($signed(src1_s) < $signed(src2_s));
  assign ltu_s   = (src1_s < src2_s);

  // Branch codes 000 and 111 fall through to the not-taken default.
  exe_key_mux #(.NR_KEY(6), .KEY_LEN(3), .DATA_LEN(1)) u_branch_mux (
    .key         (branch_type_i),
    .default_val (1'b0),
    .lut         ({3'b110, ~ltu_s, 3'b101, ltu_s, 3'b100, ~lt_s,
                   3'b011, lt_s, 3'b010, ~zero_s, 3'b001, zero_s}),
    .data        (branch_s)
  );

  // ALU operation decode.
  always_comb begin
    alu_res_s = {DATA_LEN{1'b0}};
    case (alu_control)
      4'b0000: alu_res_s = src1_s + src2_s;
      4'b0001: alu_res_s = src1_s - src2_s;
      4'b0010: alu_res_s = src1_s & src2_s;
      4'b0011: alu_res_s = src1_s | src2_s;
      4'b0100: alu_res_s = src1_s ^ src2_s;
      4'b0101: alu_res_s = src1_s << shamt_s;
      4'b0110: alu_res_s = src1_s >> shamt_s;
      4'b0111: alu_res_s = DATA_LEN'($signed(src1_s) >>> shamt_s);
      4'b1000: alu_res_s = {{(DATA_LEN-1){1'b0}}, lt_s};
      4'b1001: alu_res_s = {{(DATA_LEN-1){1'b0}}, ltu_s};
      4'b1010: alu_res_s = src2_s;
      default: alu_res_s = {DATA_LEN{1'b0}};
    endcase
  end

  // Store byte-lane mask from the store size.
  always_comb begin
    store_mask_s = {DATA_LEN{1'b0}};
    case (store_type_i)
      2'b01:   store_mask_s = 32'h0000_00FF;
      2'b10:   store_mask_s = 32'h0000_FFFF;
      2'b11:   store_mask_s = 32'hFFFF_FFFF;
      default: store_mask_s = {DATA_LEN{1'b0}};
    endcase
  end

  // Output stage: controls drop when idle, datapath values hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      alu_result_o     <= {DATA_LEN{1'b0}};
      branch_request_o <= 1'b0;
      mem_wen_o        <= 1'b0;
      mem_wdata_o      <= {DATA_LEN{1'b0}};
      wd_o             <= 1'b0;
      wreg_o           <= 5'd0;
      load_type_o      <= 3'd0;
    end else if (in_valid) begin
      out_valid        <= 1'b1;
      alu_result_o     <= alu_res_s;
      branch_request_o <= branch_s;
      mem_wen_o        <= |store_type_i;
      mem_wdata_o      <= reg2_i & store_mask_s;
      wd_o             <= wd_i;
      wreg_o           <= wreg_i;
      load_type_o      <= load_type_i;
    end else begin
      out_valid        <= 1'b0;
      branch_request_o <= 1'b0;
      mem_wen_o        <= 1'b0;
      wd_o             <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exe_alu_stage.sv
// Directed bench for exe_alu_stage with hand-computed expected values.

module tb_exe_alu_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] reg1_i, reg2_i, pc_i, imm_i;
  logic [3:0]  alu_control, alu_sel;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [1:0]  store_type_i;
  logic [2:0]  load_type_i, branch_type_i;
  logic        out_valid, branch_request_o, mem_wen_o, wd_o;
  logic [31:0] alu_result_o, mem_wdata_o;
  logic [4:0]  wreg_o;
  logic [2:0]  load_type_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_alu_stage #(.DATA_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .pc_i(pc_i), .imm_i(imm_i),
    .alu_control(alu_control), .alu_sel(alu_sel),
    .wd_i(wd_i), .wreg_i(wreg_i), .store_type_i(store_type_i),
    .load_type_i(load_type_i), .branch_type_i(branch_type_i),
    .out_valid(out_valid), .alu_result_o(alu_result_o),
    .branch_request_o(branch_request_o), .mem_wen_o(mem_wen_o),
    .mem_wdata_o(mem_wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .load_type_o(load_type_o)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [3:0] sel, input logic [3:0] ctrl);
    alu_sel     = sel;
    alu_control = ctrl;
  endtask

  initial begin
    // Reset with a busy, arbitrary input bundle
    rst_n = 1'b0; in_valid = 1'b1;
    reg1_i = 32'h1234_5678; reg2_i = 32'hCAFE_F00D; pc_i = 32'h0000_0100; imm_i = 32'h0000_0042;
    alu_sel = 4'b0101; alu_control = 4'b0000; wd_i = 1'b1; wreg_i = 5'd9;
    store_type_i = 2'b11; load_type_i = 3'b101; branch_type_i = 3'b010;
    step();
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu_result", alu_result_o, 32'd0);
    check("rst_branch", {31'd0, branch_request_o}, 32'd0);
    check("rst_mem_wen", {31'd0, mem_wen_o}, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_wd", {31'd0, wd_o}, 32'd0);
    check("rst_wreg", {27'd0, wreg_o}, 32'd0);
    check("rst_load_type", {29'd0, load_type_o}, 32'd0);

    // ADD wraps: reg1 + imm
    rst_n = 1'b1;
    reg1_i = 32'hFFFF_FFFF; imm_i = 32'd1; alu_op(4'b1001, 4'b0000);
    wd_i = 1'b1; wreg_i = 5'd7; load_type_i = 3'b010; store_type_i = 2'b00; branch_type_i = 3'b000;
    step();
    check("add_wrap", alu_result_o, 32'h0000_0000);
    check("add_out_valid", {31'd0, out_valid}, 32'd1);
    check("add_wd", {31'd0, wd_o}, 32'd1);
    check("add_wreg", {27'd0, wreg_o}, 32'd7);
    check("add_load_type", {29'd0, load_type_o}, 32'd2);
    check("add_mem_wen", {31'd0, mem_wen_o}, 32'd0);

    // SUB wraps
    reg1_i = 32'd0; reg2_i = 32'd1; alu_op(4'b0101, 4'b0001);
    step();
    check("sub_wrap", alu_result_o, 32'hFFFF_FFFF);

    // Shifts and compares
    reg1_i = 32'h8000_0000; reg2_i = 32'd4;
    alu_op(4'b0101, 4'b0111); step(); check("sra", alu_result_o, 32'hF800_0000);
    alu_op(4'b0101, 4'b0110); step(); check("srl", alu_result_o, 32'h0800_0000);
    alu_op(4'b0101, 4'b0101); step(); check("sll", alu_result_o, 32'h0000_0000);
    alu_op(4'b0101, 4'b1000); step(); check("slt", alu_result_o, 32'd1);
    alu_op(4'b0101, 4'b1001); step(); check("sltu", alu_result_o, 32'd0);
    alu_op(4'b0101, 4'b0100); step(); check("xor", alu_result_o, 32'h8000_0004);
    imm_i = 32'h1234_5000;
    alu_op(4'b1000, 4'b1010); step(); check("pass2_lui", alu_result_o, 32'h1234_5000);
    alu_op(4'b0101, 4'b1100); step(); check("illegal_op", alu_result_o, 32'd0);

    // JAL link: pc + 4
    pc_i = 32'h8000_0010;
    alu_op(4'b1110, 4'b0000); step(); check("jal_link", alu_result_o, 32'h8000_0014);

    // Branches with reg1=-1, reg2=1
    reg1_i = 32'hFFFF_FFFF; reg2_i = 32'd1; alu_op(4'b0101, 4'b0000);
    branch_type_i = 3'b011; step(); check("blt", {31'd0, branch_request_o}, 32'd1);
    branch_type_i = 3'b100; step(); check("bge", {31'd0, branch_request_o}, 32'd0);
    branch_type_i = 3'b101; step(); check("bltu", {31'd0, branch_request_o}, 32'd0);
    branch_type_i = 3'b110; step(); check("bgeu", {31'd0, branch_request_o}, 32'd1);
    reg1_i = 32'd5; reg2_i = 32'd5;
    branch_type_i = 3'b001; step(); check("beq", {31'd0, branch_request_o}, 32'd1);
    branch_type_i = 3'b010; step(); check("bne", {31'd0, branch_request_o}, 32'd0);
    branch_type_i = 3'b000; step(); check("br_none", {31'd0, branch_request_o}, 32'd0);
    branch_type_i = 3'b111; step(); check("br_111", {31'd0, branch_request_o}, 32'd0);

    // Stores of 0xDEADBEEF
    reg1_i = 32'd0; reg2_i = 32'hDEAD_BEEF; branch_type_i = 3'b000; wreg_i = 5'd12;
    store_type_i = 2'b01; step();
    check("sb_wdata", mem_wdata_o, 32'h0000_00EF);
    check("sb_wen", {31'd0, mem_wen_o}, 32'd1);
    store_type_i = 2'b10; step(); check("sh_wdata", mem_wdata_o, 32'h0000_BEEF);
    store_type_i = 2'b11; branch_type_i = 3'b010; step();
    check("sw_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    check("sw_branch", {31'd0, branch_request_o}, 32'd1);
    check("sw_alu", alu_result_o, 32'hDEAD_BEEF);

    // Idle cycle: controls drop, data holds
    in_valid = 1'b0; reg1_i = 32'h1111_1111; reg2_i = 32'h2222_2222; wreg_i = 5'd3; load_type_i = 3'b111;
    step();
    check("idle_mem_wen", {31'd0, mem_wen_o}, 32'd0);
    check("idle_wd", {31'd0, wd_o}, 32'd0);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_branch", {31'd0, branch_request_o}, 32'd0);
    check("idle_wdata_hold", mem_wdata_o, 32'hDEAD_BEEF);
    check("idle_alu_hold", alu_result_o, 32'hDEAD_BEEF);
    check("idle_wreg_hold", {27'd0, wreg_o}, 32'd12);
    check("idle_load_hold", {29'd0, load_type_o}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/exe_alu_stage.md
Name: exe_alu_stage

Overview:
- Registered RV32 execute-stage datapath: selects ALU operands, computes the ALU result, evaluates the branch condition, masks store data, and forwards writeback and load control.
- Sits between decode/issue and the memory/writeback stage.
- Contains an internal key-match mux helper (key, data pairs; default value on no match) for operand and branch selection.
- Latency is 1 cycle.

Parameters:
- DATA_LEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input bundle valid this cycle
- reg1_i  in  32  rs1 value
- reg2_i  in  32  rs2 value; also the store data
- pc_i  in  32  instruction PC
- imm_i  in  32  sign-extended immediate
- alu_control  in  4  ALU operation
- alu_sel  in  4  [1:0] src1 select, [3:2] src2 select
- wd_i  in  1  register writeback enable
- wreg_i  in  5  destination register index
- store_type_i  in  2  00 none, 01 SB, 10 SH, 11 SW
- load_type_i  in  3  load type, passed through
- branch_type_i  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 none
- out_valid  out  1  registered in_valid
- alu_result_o  out  32  ALU result
- branch_request_o  out  1  branch taken
- mem_wen_o  out  1  store request
- mem_wdata_o  out  32  masked store data
- wd_o  out  1  writeback enable
- wreg_o  out  5  destination register index
- load_type_o  out  3  load type

Behaviour:
- Reset: if rst_n=0 at a rising clk edge, every output register is cleared to 0. Reset has priority over in_valid.
- Capture: each rising edge with rst_n=1 and in_valid=1 registers all outputs from the current inputs.
- Idle: on an edge with in_valid=0, out_valid, mem_wen_o, wd_o and branch_request_o go to 0. alu_result_o, mem_wdata_o, wreg_o and load_type_o hold their previous values.
- src1 select (alu_sel[1:0]): 00 -> 0, 01 -> reg1_i, 10 -> pc_i, 11 -> 0 (default).
- src2 select (alu_sel[3:2]): 00 -> 0, 01 -> reg2_i, 10 -> imm_i, 11 -> 32'd4.
- ALU ops (alu_control):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount = src2[4:0]
  - 1000 SLT (signed, result 1/0), 1001 SLTU (unsigned, result 1/0)
  - 1010 PASS2 (result = src2, for LUI)
  - 1011-1111 -> result 0
- Arithmetic: ADD/SUB wrap modulo 2^32. No overflow or carry outputs.
- Flags (internal, independent of alu_control):
  - zero = (src1 == src2)
  - lt = signed src1 < src2
  - ltu = unsigned src1 < src2
- Branch decision:
  - BEQ -> zero, BNE -> ~zero
  - BLT -> lt, BGE -> ~lt
  - BLTU -> ltu, BGEU -> ~ltu
  - 000 and 111 -> 0
- Store:
  - mem_wen_o = |store_type_i
  - mask: SB 0x000000FF, SH 0x0000FFFF, SW 0xFFFFFFFF, none 0
  - mem_wdata_o = reg2_i & mask
- Pass-through: wd_o, wreg_o and load_type_o are registered copies of their inputs. No decode of load_type.
- Determinism: no $display or other simulation side effects; fully synthesizable.
- Helper mux: parameterised on NR_KEY, KEY_LEN and DATA_LEN. Outputs the data of the first matching key, else the default value; purely combinational.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 and arbitrary inputs -> all outputs 0. Release; the next valid input appears on outputs 1 cycle later.
- ADD/SUB wrap: src1=reg1=0xFFFFFFFF, src2=imm=1, ADD -> alu_result_o=0. Then reg1=0, reg2=1, SUB -> 0xFFFFFFFF.
- Shifts and compares: reg1=0x80000000, reg2=4:
  - SRA -> 0xF8000000, SRL -> 0x08000000
  - SLT -> 1, SLTU -> 0
- JAL link path: alu_sel=4'b1110 (src1 = pc_i = 0x80000010, src2 = 4), ADD -> alu_result_o=0x80000014.
- Branches: reg1=-1, reg2=1:
  - BLT -> 1, BGE -> 0, BLTU -> 0, BGEU -> 1
  - with reg1=reg2: BEQ -> 1, BNE -> 0
  - branch_type=000 -> 0
- Store and idle: reg2=0xDEADBEEF:
  - SB -> mem_wdata_o 0x000000EF, mem_wen_o 1
  - SH -> 0x0000BEEF
  - SW -> 0xDEADBEEF
  - next cycle in_valid=0 -> mem_wen_o, wd_o, out_valid 0 and mem_wdata_o held
